// File: rtl/vga_timing_pkg.sv
// ----------------------------------------------------------------------------
// vga_timing_pkg : default 640x480@60 timing constants shared with renderers.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package vga_timing_pkg;

  localparam int CNT_W = 10;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  function automatic int scan_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  localparam int DEF_H_TOTAL = scan_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
  localparam int DEF_V_TOTAL = scan_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

endpackage

`default_nettype wire

// File: rtl/vga_scan_gen_if.sv
// ----------------------------------------------------------------------------
// vga_scan_gen_if : renderer position/colour bus plus registered pin outputs.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface vga_scan_gen_if;

  logic [vga_timing_pkg::CNT_W-1:0] row;
  logic [vga_timing_pkg::CNT_W-1:0] col;
  logic                             red;
  logic                             green;
  logic                             blue;
  logic                             vga_r;
  logic                             vga_g;
  logic                             vga_b;
  logic                             hsync;
  logic                             vsync;
  logic                             frame_start;
  logic                             vblank_start;

  modport master (
    output row, col, vga_r, vga_g, vga_b, hsync, vsync, frame_start, vblank_start,
    input  red, green, blue
  );

  modport slave (
    input  row, col, vga_r, vga_g, vga_b, hsync, vsync, frame_start, vblank_start,
    output red, green, blue
  );

endinterface

`default_nettype wire

// File: rtl/scan_counter.sv
// ----------------------------------------------------------------------------
// scan_counter : enabled modulo-MODULO counter with a same-edge wrap flag.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module scan_counter #(
  parameter int MODULO = 800,
  parameter int WIDTH  = 10
) (
  input  wire logic             CLK,
  input  wire logic             RST,
  input  wire logic             en_i,
  output logic [WIDTH-1:0]      cnt_o,
  output logic                  wrap_o
);

  localparam logic [WIDTH-1:0] c_last = WIDTH'(MODULO - 1);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // wrap_o marks the enabled edge that returns the count to zero
  assign wrap_o = en_i && (cnt_q == c_last);
  assign cnt_o  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i) begin
      cnt_d = wrap_o ? '0 : cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/vga_scan_gen.sv
// ----------------------------------------------------------------------------
// vga_scan_gen : VGA raster scan generator with blanked colour, sync, strobes.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module vga_scan_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  wire logic      CLK,
  input  wire logic      RST,
  input  wire logic      PIX_EN,
  vga_scan_gen_if.master vga
);

  localparam int H_TOTAL = scan_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = scan_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [CNT_W-1:0] c_h_act    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] c_hs_begin = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] c_hs_end   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] c_v_act    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] c_vs_begin = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] c_vs_end   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [CNT_W-1:0] w_hcnt;
  logic [CNT_W-1:0] w_vcnt;
  logic             w_h_wrap;
  logic             w_v_wrap;
  logic             w_active;

  logic [2:0] rgb_q,          rgb_d;
  logic       hsync_q,        hsync_d;
  logic       vsync_q,        vsync_d;
  logic       frame_start_q,  frame_start_d;
  logic       vblank_start_q, vblank_start_d;
  logic       at_origin_q,    at_origin_d;

  scan_counter #(.MODULO(H_TOTAL), .WIDTH(CNT_W)) u_hcnt (
    .CLK    (CLK),
    .RST    (RST),
    .en_i   (PIX_EN),
    .cnt_o  (w_hcnt),
    .wrap_o (w_h_wrap)
  );

  scan_counter #(.MODULO(V_TOTAL), .WIDTH(CNT_W)) u_vcnt (
    .CLK    (CLK),
    .RST    (RST),
    .en_i   (w_h_wrap),
    .cnt_o  (w_vcnt),
    .wrap_o (w_v_wrap)
  );

  assign w_active = (w_hcnt < c_h_act) && (w_vcnt < c_v_act);

  always_comb begin
    rgb_d          = rgb_q;
    hsync_d        = hsync_q;
    vsync_d        = vsync_q;
    frame_start_d  = frame_start_q;
    vblank_start_d = vblank_start_q;
    at_origin_d    = at_origin_q;
    if (PIX_EN) begin
      rgb_d          = {vga.red, vga.green, vga.blue} & {3{w_active}};
      hsync_d        = !((w_hcnt >= c_hs_begin) && (w_hcnt < c_hs_end));
      vsync_d        = !((w_vcnt >= c_vs_begin) && (w_vcnt < c_vs_end));
      // at_origin_q mirrors "counters at (0,0)"; only a full-frame wrap lands there
      frame_start_d  = at_origin_q;
      vblank_start_d = (w_hcnt == '0) && (w_vcnt == c_v_act);
      at_origin_d    = w_v_wrap;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rgb_q          <= 3'b000;
      hsync_q        <= 1'b1;
      vsync_q        <= 1'b1;
      frame_start_q  <= 1'b0;
      vblank_start_q <= 1'b0;
      at_origin_q    <= 1'b1;
    end else begin
      rgb_q          <= rgb_d;
      hsync_q        <= hsync_d;
      vsync_q        <= vsync_d;
      frame_start_q  <= frame_start_d;
      vblank_start_q <= vblank_start_d;
      at_origin_q    <= at_origin_d;
    end
  end

  assign vga.row          = w_vcnt;
  assign vga.col          = w_hcnt;
  assign vga.vga_r        = rgb_q[2];
  assign vga.vga_g        = rgb_q[1];
  assign vga.vga_b        = rgb_q[0];
  assign vga.hsync        = hsync_q;
  assign vga.vsync        = vsync_q;
  assign vga.frame_start  = frame_start_q;
  assign vga.vblank_start = vblank_start_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_scan_gen.sv
// ----------------------------------------------------------------------------
// tb_vga_scan_gen : scoreboard bench for a shrunken-timing scan generator,
// plus line-timing checks on a default 640x480 instance.
// ----------------------------------------------------------------------------
`default_nettype none

module tb_vga_scan_gen;

  localparam int SH_ACT = 8, SH_FP = 2, SH_SYNC = 3, SH_BP = 2;
  localparam int SV_ACT = 4, SV_FP = 1, SV_SYNC = 2, SV_BP = 1;
  localparam int SH_TOT = SH_ACT + SH_FP + SH_SYNC + SH_BP;
  localparam int SV_TOT = SV_ACT + SV_FP + SV_SYNC + SV_BP;
  localparam int FRAME  = SH_TOT * SV_TOT;

  typedef struct packed {
    logic [2:0] rgb;
    logic       hs;
    logic       vs;
    logic       fs;
    logic       vb;
  } exp_t;

  logic CLK;
  logic RST;
  logic PIX_EN;
  int   mode;

  int   n_chk;
  int   n_err;

  int   mh, mv;
  exp_t last_e;
  exp_t sb_q[$];

  bit   dmon;
  int   d_edge, d_fs_first, d_fall1, d_fall2, d_len;
  logic d_prev_hs;
  logic [2:0] d_rgb_e1, d_rgb_e641;

  vga_scan_gen_if sif ();
  vga_scan_gen_if dif ();

  function automatic logic [2:0] colour(input int m, input int r, input int c);
    logic [2:0] v;
    case (m)
      0:       v = 3'b111;
      1:       v = {3{c[0]}};
      default: v = {c[0] ^ r[0], c[1], r[1] ^ c[2]};
    endcase
    return v;
  endfunction

  logic [2:0] w_src;
  assign w_src     = colour(mode, int'(sif.row), int'(sif.col));
  assign sif.red   = w_src[2];
  assign sif.green = w_src[1];
  assign sif.blue  = w_src[0];
  assign dif.red   = 1'b1;
  assign dif.green = 1'b1;
  assign dif.blue  = 1'b1;

  vga_scan_gen #(
    .H_ACTIVE (SH_ACT), .H_FP (SH_FP), .H_SYNC (SH_SYNC), .H_BP (SH_BP),
    .V_ACTIVE (SV_ACT), .V_FP (SV_FP), .V_SYNC (SV_SYNC), .V_BP (SV_BP)
  ) u_small (
    .CLK    (CLK),
    .RST    (RST),
    .PIX_EN (PIX_EN),
    .vga    (sif.master)
  );

  vga_scan_gen u_dflt (
    .CLK    (CLK),
    .RST    (RST),
    .PIX_EN (PIX_EN),
    .vga    (dif.master)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mh     = 0;
    mv     = 0;
    last_e = '{rgb: 3'b000, hs: 1'b1, vs: 1'b1, fs: 1'b0, vb: 1'b0};
  endtask

  // One CLK cycle: check position, push the expected registered outputs, compare after the edge
  task automatic step(input bit en);
    exp_t e;
    check_eq("col", 32'(sif.col), mh);
    check_eq("row", 32'(sif.row), mv);
    PIX_EN = en;
    e = last_e;
    if (en) begin
      e.rgb = (mh < SH_ACT && mv < SV_ACT) ? colour(mode, mv, mh) : 3'b000;
      e.hs  = !(mh >= SH_ACT + SH_FP && mh < SH_ACT + SH_FP + SH_SYNC);
      e.vs  = !(mv >= SV_ACT + SV_FP && mv < SV_ACT + SV_FP + SV_SYNC);
      e.fs  = (mh == 0 && mv == 0);
      e.vb  = (mh == 0 && mv == SV_ACT);
      mh++;
      if (mh == SH_TOT) begin
        mh = 0;
        mv++;
        if (mv == SV_TOT) mv = 0;
      end
    end
    last_e = e;
    sb_q.push_back(e);
    @(posedge CLK);
    @(negedge CLK);
    e = sb_q.pop_front();
    check_eq("vga_rgb",      32'({sif.vga_r, sif.vga_g, sif.vga_b}), 32'(e.rgb));
    check_eq("hsync",        32'(sif.hsync), 32'(e.hs));
    check_eq("vsync",        32'(sif.vsync), 32'(e.vs));
    check_eq("frame_start",  32'(sif.frame_start), 32'(e.fs));
    check_eq("vblank_start", 32'(sif.vblank_start), 32'(e.vb));
    if (dmon) begin
      d_edge++;
      if (dif.frame_start && d_fs_first == 0) d_fs_first = d_edge;
      if (d_edge == 1)   d_rgb_e1   = {dif.vga_r, dif.vga_g, dif.vga_b};
      if (d_edge == 641) d_rgb_e641 = {dif.vga_r, dif.vga_g, dif.vga_b};
      if (!dif.hsync && d_prev_hs) begin
        if (d_fall1 == 0) d_fall1 = d_edge;
        else if (d_fall2 == 0) d_fall2 = d_edge;
      end
      if (!dif.hsync && d_fall2 == 0) d_len++;
      d_prev_hs = dif.hsync;
    end
  endtask

  task automatic check_reset_outputs(input string who);
    check_eq({who, "_row"},   32'(sif.row), 0);
    check_eq({who, "_col"},   32'(sif.col), 0);
    check_eq({who, "_rgb"},   32'({sif.vga_r, sif.vga_g, sif.vga_b}), 0);
    check_eq({who, "_hsync"}, 32'(sif.hsync), 1);
    check_eq({who, "_vsync"}, 32'(sif.vsync), 1);
    check_eq({who, "_fs"},    32'(sif.frame_start), 0);
    check_eq({who, "_vb"},    32'(sif.vblank_start), 0);
  endtask

  initial begin
    n_chk = 0; n_err = 0;
    dmon = 1'b0; d_edge = 0; d_fs_first = 0; d_fall1 = 0; d_fall2 = 0; d_len = 0;
    d_prev_hs = 1'b1; d_rgb_e1 = 3'b000; d_rgb_e641 = 3'b111;
    mode = 0;
    RST = 1'b0;
    PIX_EN = 1'b1;
    model_reset();
    repeat (3) @(negedge CLK);
    check_reset_outputs("rst");
    check_eq("dflt_rst_hsync", 32'(dif.hsync), 1);
    check_eq("dflt_rst_vsync", 32'(dif.vsync), 1);
    check_eq("dflt_rst_fs",    32'(dif.frame_start), 0);
    check_eq("dflt_rst_col",   32'(dif.col), 0);

    #2 RST = 1'b1;
    dmon = 1'b1;
    repeat (1500) step(1'b1);
    dmon = 1'b0;
    check_eq("dflt_fs_edge",    d_fs_first, 1);
    check_eq("dflt_rgb_pix0",   32'(d_rgb_e1), 32'(3'b111));
    check_eq("dflt_rgb_col640", 32'(d_rgb_e641), 0);
    check_eq("dflt_hs_fall",    d_fall1, 657);
    check_eq("dflt_hs_len",     d_len, 96);
    check_eq("dflt_line",       d_fall2 - d_fall1, 800);

    mode = 1;
    repeat (2 * FRAME) step(1'b1);

    mode = 2;
    repeat (2 * FRAME) begin
      step(1'b1);
      step(1'b0);
    end
    repeat (300) step(1'($urandom_range(0, 1)));

    mode = 0;
    for (int i = 0; i < 4 * FRAME && !(mh == 5 && mv == 2); i++) step(1'b1);
    check_eq("reach_rst_point", 32'(mh == 5 && mv == 2), 1);
    #2 RST = 1'b0;
    #1 check_reset_outputs("async_rst");
    model_reset();
    PIX_EN = 1'b1;
    repeat (2) @(negedge CLK);
    check_reset_outputs("rst_hold");
    #2 RST = 1'b1;
    step(1'b0);
    step(1'b0);
    repeat (2 * FRAME + 5) step(1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/vga_scan_gen.md
VGA_SCAN_GEN -- requirements
Module: vga_scan_gen

Interface
REQ-001 Parameter H_ACTIVE, 640, visible pixels per line.
REQ-002 Parameter H_FP, 16, horizontal front porch in pixels.
REQ-003 Parameter H_SYNC, 96, horizontal sync width in pixels.
REQ-004 Parameter H_BP, 48, horizontal back porch in pixels.
REQ-005 Parameter V_ACTIVE, 480, visible lines per frame.
REQ-006 Parameter V_FP, 10, vertical front porch in lines.
REQ-007 Parameter V_SYNC, 2, vertical sync width in lines.
REQ-008 Parameter V_BP, 33, vertical back porch in lines.
REQ-009 Port CLK, input, 1, single system clock, rising edge.
REQ-010 Port RST, input, 1, asynchronous active-low reset.
REQ-011 Port PIX_EN, input, 1, pixel-rate clock enable; all state advances only when high.
REQ-012 Port row, output, 10, current line counter, to the pixel renderer.
REQ-013 Port col, output, 10, current pixel counter, to the pixel renderer.
REQ-014 Port red/green/blue, input, 1 each, renderer colour for the current row/col, combinational from row/col.
REQ-015 Port vga_r/vga_g/vga_b, output, 1 each, registered, blanked colour to the pins.
REQ-016 Port hsync/vsync, output, 1 each, registered sync, active-low.
REQ-017 Port frame_start, output, 1, one-PIX_EN-period strobe at the start of each frame.
REQ-018 Port vblank_start, output, 1, one-PIX_EN-period strobe when the first non-visible line begins; used to update mu/maxrepeat between frames.

Function
REQ-019 H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 525); both counts SHALL fit in 10 bits.
REQ-020 Counter hcnt SHALL increment on each CLK edge with PIX_EN=1 and wrap from H_TOTAL-1 to 0.
REQ-021 Counter vcnt SHALL increment only when hcnt wraps, and wrap from V_TOTAL-1 to 0 on the same edge.
REQ-022 When PIX_EN=0, counters and all registered outputs SHALL hold.
REQ-023 col SHALL equal hcnt and row SHALL equal vcnt, unregistered from the counters, over the full range including blanking.
REQ-024 active SHALL be hcnt<H_ACTIVE and vcnt<V_ACTIVE, evaluated on the current counters.
REQ-025 vga_r/g/b SHALL register {red,green,blue} AND active on each PIX_EN edge; latency is one PIX_EN period after row/col.
REQ-026 hsync SHALL register low when H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC, else high; it carries the same one-period delay as colour.
REQ-027 vsync SHALL register low when V_ACTIVE+V_FP <= vcnt < V_ACTIVE+V_FP+V_SYNC, else high; it carries the same one-period delay as colour.
REQ-028 frame_start SHALL register high for one PIX_EN period when hcnt==0 and vcnt==0, aligned with pixel (0,0) at vga_r/g/b.
REQ-029 vblank_start SHALL register high for one PIX_EN period when hcnt==0 and vcnt==V_ACTIVE.
REQ-030 A strobe SHALL stay asserted through intervening PIX_EN=0 cycles and deassert at the next PIX_EN edge.
REQ-031 PIX_EN held permanently high SHALL give one pixel per CLK with no bubbles.

Reset
REQ-032 RST=0 SHALL immediately clear hcnt and vcnt to 0.
REQ-033 RST=0 SHALL immediately set vga_r/g/b=0, hsync=1, vsync=1, frame_start=0 and vblank_start=0.
REQ-034 Reset asserted mid-frame SHALL abort the frame; after release the first PIX_EN edge SHALL process pixel (0,0).

Structure
REQ-035 Default timing constants and the derived H_TOTAL/V_TOTAL SHALL live in a shared package (vga_timing_pkg) for reuse by renderers.
REQ-036 One sub-module, scan_counter (parameterised modulo counter with enable and wrap output), SHALL be instantiated twice, for horizontal and vertical.

Verification
REQ-037 Reset release, PIX_EN=1, renderer colour tied to 3'b111 -> frame_start high on cycle 1; hsync low for exactly 96 cycles starting 657 cycles after frame_start rises; line period 800 cycles.
REQ-038 Run one full frame -> vsync low for exactly 2x800 cycles starting at line 490; frame period 420000 cycles; vblank_start rises once, at line 480, pixel 0.
REQ-039 Colour = col[0] -> vga_r/g/b alternate per pixel for col 0..639, and stay 0 for col 640..799 and rows 480..524.
REQ-040 PIX_EN toggling 1,0,1,0 -> col advances every second CLK; one frame takes 840000 CLK; all strobes stay high for 2 CLK.
REQ-041 Assert RST at row 200, col 300 -> outputs reset asynchronously; after release row=0 and col=0, and frame_start follows on the first PIX_EN edge.
REQ-042 Counter wrap check: at row 524, col 799 -> the next PIX_EN edge gives row=0 and col=0 on the same edge, with frame_start asserted.
